dma_mc: RTL and testbench
=========================

// Module: dma_mc
// PURPOSE
//  Multi-channel DMA engine; parametrised successor of the single-channel DRAM DMA.
//  NCH independent channels, each with 2D transfer geometry (LEN x NUM words) and optional per-burst stride.
//  Modes: device->RAM, RAM->device, RAM->RAM. Channels share one 16-bit datapath.
//  Whole bursts are granted round-robin. Sits between the Z80 port decoder, the DRAM arbiter and the device mux.
// PARAMETERS
//  NCH  4   number of channels (2..8)
//  AW   21  DRAM word-address width
//  LW   8   burst-length counter width
//  NW   8   burst-count counter width
// PORTS
//  clk          in   1         system clock
//  reset        in   1         synchronous, active-high
//  reg_we       in   1         register write strobe, one cycle
//  reg_ch       in   clog2NCH  target channel
//  reg_idx      in   4         register index (map below)
//  reg_wdata    in   8         write data
//  dram_addr    out  AW        DRAM word address
//  dram_req     out  1         DRAM request, level
//  dram_rnw     out  1         1=read, 0=write
//  dram_next    in   1         DRAM word done, one cycle
//  dram_rddata  in   16        DRAM read data, valid with dram_next
//  dram_wrdata  out  16        DRAM write data
//  dev_req      out  1         device request, level
//  dev_rnw      out  1         1=device read, 0=device write
//  dev_ch       out  clog2NCH  owning channel (selects device)
//  dev_stb      in   1         device word done, one cycle
//  dev_rddata   in   16        device read data, valid with dev_stb
//  dev_wrdata   out  16        device write data
//  ch_act       out  NCH       channel busy flags
//  int_done     out  NCH       one-cycle completion pulse per channel
// BEHAVIOUR
//  Register map:
//   0-2  SADDR L/M/H
//   3-5  DADDR L/M/H; bytes of AW-bit word address, H truncated to AW-16 bits
//   6    LEN-1
//   7    NUM-1
//   8    SSTRIDE
//   9    DSTRIDE; unsigned word stride
//   10   CTRL; write launches the channel
//  CTRL bits:
//   [1:0] mode: 0 dev->RAM, 1 RAM->dev, 2 RAM->RAM, 3 abort
//   [2]   salgn
//   [3]   dalgn
//   [4]   ie
//  Register writes:
//   - Writes to an active channel are ignored, except CTRL mode 3.
//   - CTRL mode 3 on an idle channel: no effect.
//  Reset: all ch_act=0, all requests 0, int_done=0, data/addr outputs 0, FSM=IDLE. Register contents undefined.
//  FSM states: IDLE, ARB, RD, WR.
//   IDLE -> ARB when any ch_act.
//   ARB (1 cycle) grants the first active channel after the last owner (round-robin), loads dev_ch -> RD.
//   RD: source RAM -> dram_req=1, dram_rnw=1, dram_addr=src, until dram_next.
//       source device -> dev_req=1, dev_rnw=1, until dev_stb.
//       Data register captured on the done strobe -> WR.
//   WR: destination RAM or device, rnw=0, data=register, until dram_next or dev_stb.
//  Word completion (done strobe in WR):
//   - Burst words remain -> RD, same owner.
//   - Burst exhausted -> ARB if any channel active, else IDLE.
//  Addresses:
//   - Linear: +1 per word, modulo 2^AW.
//   - salgn/dalgn=1: at burst end, address = burst-start + STRIDE (modulo 2^AW); within a burst still +1.
//  Counts: total words = (LEN+1)*(NUM+1); LEN=0,NUM=0 transfers exactly 1 word.
//  Completion: ch_act clears the cycle after the final WR done strobe. int_done pulses that same cycle if ie=1.
//  Abort:
//   - Owner: finishes the current RD+WR word, then clears ch_act, no int_done.
//   - Non-owner: cleared next cycle.
//  Launch and completion in the same cycle on one channel: completion wins, launch ignored.
//  A strobe arriving outside its matching request is ignored.
//  Reset mid-transfer: all requests drop next cycle, nothing resumes.
//  Latency: launch -> request asserted after 2 cycles (launch reg + ARB); 1 ARB cycle between bursts.
// STRUCTURE
//  dma_mc_pkg: register index constants, CTRL bit positions, mode enum, FSM state enum.
//  Sub-module dma_mc_chan (NCH instances): registers, LEN/NUM counters, src/dst address generators,
//   act flag, advance/abort inputs.
//  Top: round-robin arbiter, FSM, shared data register, output muxing.
// TESTING
//  - Ch0 RAM->RAM, S=0x100, D=0x200, LEN-1=3, NUM-1=0 -> 4 reads then writes to 0x200-0x203; one int_done[0]; ch_act[0] falls.
//  - Ch1 dev->RAM, LEN-1=1, NUM-1=2, dalgn=1, DSTRIDE=0x10, D=0x40 -> writes to 0x40,41,50,51,60,61.
//  - Ch0 and ch2 both launched with LEN-1=1 -> bursts alternate 0,2,0,2 with one ARB cycle between; neither starves.
//  - Abort owner mid-word -> current word completes, no further requests, int_done stays 0.
//  - S=2^AW-1 linear, 2 words -> second read at address 0 (wrap).
//  - Reset asserted during WR -> dram_req, dev_req and ch_act all 0 on the next cycle.

Source files
------------

// File: rtl/dma_mc_pkg.sv
// Shared definitions for the multi-channel DMA: register map, CTRL fields, modes and FSM states.
package dma_mc_pkg;

   localparam logic [3:0] REG_SADDR_L = 4'd0;
   localparam logic [3:0] REG_SADDR_M = 4'd1;
   localparam logic [3:0] REG_SADDR_H = 4'd2;
   localparam logic [3:0] REG_DADDR_L = 4'd3;
   localparam logic [3:0] REG_DADDR_M = 4'd4;
   localparam logic [3:0] REG_DADDR_H = 4'd5;
   localparam logic [3:0] REG_LEN     = 4'd6;
   localparam logic [3:0] REG_NUM     = 4'd7;
   localparam logic [3:0] REG_SSTRIDE = 4'd8;
   localparam logic [3:0] REG_DSTRIDE = 4'd9;
   localparam logic [3:0] REG_CTRL    = 4'd10;

   localparam int CTRL_SALGN = 2;
   localparam int CTRL_DALGN = 3;
   localparam int CTRL_IE    = 4;

   typedef enum logic [1:0] {
      MODE_D2R   = 2'd0,
      MODE_R2D   = 2'd1,
      MODE_R2R   = 2'd2,
      MODE_ABORT = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARB  = 2'd1,
      ST_RD   = 2'd2,
      ST_WR   = 2'd3
   } state_t;

endpackage

// File: rtl/dma_mc_chan.sv
// One DMA channel: programming registers, 2D word counters, source/destination address generators.
// Advances one word per WR-done strobe from the top; abort of the owner is deferred to the end of its word.
module dma_mc_chan
   import dma_mc_pkg::*;
#(
   parameter int AW = 21,
   parameter int LW = 8,
   parameter int NW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          reg_we,
   input  logic [3:0]    reg_idx,
   input  logic [7:0]    reg_wdata,
   input  logic          is_cur,
   input  logic          advance,
   output logic          act,
   output mode_t         mode,
   output logic [AW-1:0] src_addr,
   output logic [AW-1:0] dst_addr,
   output logic          burst_end,
   output logic          fin,
   output logic          int_done
);

   logic [AW-1:0] saddr, daddr, sbase, dbase, src_nb, dst_nb;
   logic [LW-1:0] len_m1, len_cnt;
   logic [NW-1:0] num_m1, num_cnt;
   logic [7:0]    sstride, dstride;
   logic          salgn, dalgn, ie, abort_pend;
   logic          ctrl_wr, launch, abort_req, abort_now, last_word;

   assign ctrl_wr   = reg_we && (reg_idx == REG_CTRL);
   assign abort_req = ctrl_wr && act && (reg_wdata[1:0] == MODE_ABORT);
   assign launch    = ctrl_wr && !act && (reg_wdata[1:0] != MODE_ABORT);
   assign abort_now = abort_pend || (abort_req && is_cur);
   assign last_word = (len_cnt == '0) && (num_cnt == '0);
   assign burst_end = (len_cnt == '0) || abort_now;
   assign fin       = advance && (last_word || abort_now);

   // Aligned mode jumps from the burst start; linear mode just keeps counting.
   assign src_nb = salgn ? sbase + AW'(sstride) : src_addr + AW'(1);
   assign dst_nb = dalgn ? dbase + AW'(dstride) : dst_addr + AW'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         act        <= 1'b0;
         int_done   <= 1'b0;
         abort_pend <= 1'b0;
      end else begin
         int_done <= 1'b0;
         if (fin) begin
            act        <= 1'b0;
            abort_pend <= 1'b0;
            int_done   <= ie && !abort_now;
         end else if (abort_req) begin
            if (is_cur) abort_pend <= 1'b1;
            else        act        <= 1'b0;
         end else if (launch) begin
            act <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reg_we && !act) begin
         case (reg_idx)
            REG_SADDR_L: saddr[7:0]     <= reg_wdata;
            REG_SADDR_M: saddr[15:8]    <= reg_wdata;
            REG_SADDR_H: saddr[AW-1:16] <= reg_wdata[AW-17:0];
            REG_DADDR_L: daddr[7:0]     <= reg_wdata;
            REG_DADDR_M: daddr[15:8]    <= reg_wdata;
            REG_DADDR_H: daddr[AW-1:16] <= reg_wdata[AW-17:0];
            REG_LEN:     len_m1         <= LW'(reg_wdata);
            REG_NUM:     num_m1         <= NW'(reg_wdata);
            REG_SSTRIDE: sstride        <= reg_wdata;
            REG_DSTRIDE: dstride        <= reg_wdata;
            default: ;
         endcase
      end
      if (launch) begin
         mode     <= mode_t'(reg_wdata[1:0]);
         salgn    <= reg_wdata[CTRL_SALGN];
         dalgn    <= reg_wdata[CTRL_DALGN];
         ie       <= reg_wdata[CTRL_IE];
         src_addr <= saddr;
         sbase    <= saddr;
         dst_addr <= daddr;
         dbase    <= daddr;
         len_cnt  <= len_m1;
         num_cnt  <= num_m1;
      end else if (advance) begin
         if (len_cnt != '0) begin
            len_cnt  <= len_cnt - LW'(1);
            src_addr <= src_addr + AW'(1);
            dst_addr <= dst_addr + AW'(1);
         end else begin
            len_cnt  <= len_m1;
            num_cnt  <= num_cnt - NW'(1);
            src_addr <= src_nb;
            sbase    <= src_nb;
            dst_addr <= dst_nb;
            dbase    <= dst_nb;
         end
      end
   end

endmodule

// File: rtl/dma_mc.sv
// Multi-channel DMA: round-robin burst arbiter, RD/WR word FSM and shared 16-bit data register.
// Launch to first request takes 2 cycles; each word waits on dram_next/dev_stb; one ARB cycle between bursts.
module dma_mc
   import dma_mc_pkg::*;
#(
   parameter int NCH = 4,
   parameter int AW  = 21,
   parameter int LW  = 8,
   parameter int NW  = 8,
   localparam int CW = $clog2(NCH)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           reg_we,
   input  logic [CW-1:0]  reg_ch,
   input  logic [3:0]     reg_idx,
   input  logic [7:0]     reg_wdata,
   output logic [AW-1:0]  dram_addr,
   output logic           dram_req,
   output logic           dram_rnw,
   input  logic           dram_next,
   input  logic [15:0]    dram_rddata,
   output logic [15:0]    dram_wrdata,
   output logic           dev_req,
   output logic           dev_rnw,
   output logic [CW-1:0]  dev_ch,
   input  logic           dev_stb,
   input  logic [15:0]    dev_rddata,
   output logic [15:0]    dev_wrdata,
   output logic [NCH-1:0] ch_act,
   output logic [NCH-1:0] int_done
);

   state_t        state, state_nx;
   logic [CW-1:0] owner, grant, cand;
   logic          grant_vld;
   logic [15:0]   data_q;
   mode_t         mode_v [NCH];
   logic [AW-1:0] src_v [NCH];
   logic [AW-1:0] dst_v [NCH];
   logic [NCH-1:0] act_v, bend_v, fin_v, int_v;
   mode_t         cur_mode;
   logic          src_ram, dst_ram, done_rd, done_wr;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      dma_mc_chan #(.AW(AW), .LW(LW), .NW(NW)) u_chan (
         .clk       (clk),
         .reset     (reset),
         .reg_we    (reg_we && (reg_ch == CW'(g))),
         .reg_idx   (reg_idx),
         .reg_wdata (reg_wdata),
         .is_cur    (((state == ST_RD || state == ST_WR) && owner == CW'(g)) ||
                     (state == ST_ARB && grant_vld && grant == CW'(g))),
         .advance   (done_wr && owner == CW'(g)),
         .act       (act_v[g]),
         .mode      (mode_v[g]),
         .src_addr  (src_v[g]),
         .dst_addr  (dst_v[g]),
         .burst_end (bend_v[g]),
         .fin       (fin_v[g]),
         .int_done  (int_v[g])
      );
   end

   assign cur_mode = mode_v[owner];
   assign src_ram  = (cur_mode != MODE_D2R);
   assign dst_ram  = (cur_mode != MODE_R2D);
   // A strobe only counts when it matches the request currently being driven.
   assign done_rd  = (state == ST_RD) && (src_ram ? dram_next : dev_stb);
   assign done_wr  = (state == ST_WR) && (dst_ram ? dram_next : dev_stb);

   // Scan from owner+1 upward; the lowest offset found last wins, so the owner itself ranks lowest.
   always_comb begin
      grant     = owner;
      grant_vld = 1'b0;
      cand      = owner;
      for (int i = NCH; i >= 1; i--) begin
         cand = CW'((int'(owner) + i) % NCH);
         if (act_v[cand]) begin
            grant     = cand;
            grant_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (|act_v) state_nx = ST_ARB;
         ST_ARB:  state_nx = grant_vld ? ST_RD : ST_IDLE;
         ST_RD:   if (done_rd) state_nx = ST_WR;
         ST_WR: begin
            if (done_wr) begin
               if (!bend_v[owner])         state_nx = ST_RD;
               else if (|(act_v & ~fin_v)) state_nx = ST_ARB;
               else                        state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         owner  <= '0;
         data_q <= '0;
      end else begin
         state <= state_nx;
         if (state == ST_ARB && grant_vld) owner <= grant;
         if (done_rd) data_q <= src_ram ? dram_rddata : dev_rddata;
      end
   end

   assign dram_req    = (state == ST_RD && src_ram) || (state == ST_WR && dst_ram);
   assign dram_rnw    = dram_req && (state == ST_RD);
   assign dram_addr   = !dram_req ? '0 : (state == ST_RD) ? src_v[owner] : dst_v[owner];
   assign dram_wrdata = data_q;
   assign dev_req     = (state == ST_RD && !src_ram) || (state == ST_WR && !dst_ram);
   assign dev_rnw     = dev_req && (state == ST_RD);
   assign dev_ch      = owner;
   assign dev_wrdata  = data_q;
   assign ch_act      = act_v;
   assign int_done    = int_v;

endmodule

// File: tb/tb_dma_mc.sv
// Bench for dma_mc: DRAM/device responders pop an expected-transaction queue filled by each scenario.
module tb_dma_mc;
   import dma_mc_pkg::*;

   localparam int NCH = 4;
   localparam int AW  = 21;
   localparam int CW  = 2;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           reg_we = 1'b0;
   logic [CW-1:0]  reg_ch = '0;
   logic [3:0]     reg_idx = '0;
   logic [7:0]     reg_wdata = '0;
   logic [AW-1:0]  dram_addr;
   logic           dram_req, dram_rnw;
   logic           dram_next;
   logic [15:0]    dram_rddata;
   logic [15:0]    dram_wrdata;
   logic           dev_req, dev_rnw;
   logic [CW-1:0]  dev_ch;
   logic           dev_stb;
   logic [15:0]    dev_rddata;
   logic [15:0]    dev_wrdata;
   logic [NCH-1:0] ch_act, int_done;

   always #5 clk = ~clk;

   dma_mc #(.NCH(NCH), .AW(AW), .LW(8), .NW(8)) dut (
      .clk(clk), .reset(reset), .reg_we(reg_we), .reg_ch(reg_ch), .reg_idx(reg_idx),
      .reg_wdata(reg_wdata), .dram_addr(dram_addr), .dram_req(dram_req), .dram_rnw(dram_rnw),
      .dram_next(dram_next), .dram_rddata(dram_rddata), .dram_wrdata(dram_wrdata),
      .dev_req(dev_req), .dev_rnw(dev_rnw), .dev_ch(dev_ch), .dev_stb(dev_stb),
      .dev_rddata(dev_rddata), .dev_wrdata(dev_wrdata), .ch_act(ch_act), .int_done(int_done)
   );

   typedef struct packed {
      logic          rnw;
      logic [AW-1:0] addr;
      logic [15:0]   data;
   } xact_t;

   xact_t         exp_q[$];
   int            checks = 0;
   int            errors = 0;
   bit            stall = 0;
   bit            stall_wr = 0;
   int            dev_cnt = 0;
   logic [CW-1:0] exp_dev_ch = '0;
   int            int_cnt [NCH] = '{default: 0};
   int            gap = 0;
   int            max_gap = 0;
   bit            gap_meas = 0;

   function automatic logic [15:0] pat(input logic [AW-1:0] a);
      return a[15:0] ^ 16'h5A5A;
   endfunction

   function automatic void push(input logic rnw, input logic [AW-1:0] a, input logic [15:0] d);
      xact_t x;
      x.rnw = rnw; x.addr = a; x.data = d;
      exp_q.push_back(x);
   endfunction

   // DRAM responder: random 0-2 cycle latency, scoreboard compare on every completed word.
   initial begin
      int wcnt;
      xact_t x, e;
      wcnt = 0;
      dram_next = 1'b0;
      dram_rddata = '0;
      forever begin
         @(negedge clk);
         dram_next = 1'b0;
         if (dram_req && !reset && !stall && !(stall_wr && !dram_rnw)) begin
            if (wcnt > 0) wcnt--;
            else begin
               wcnt = $urandom_range(0, 2);
               x.rnw  = dram_rnw;
               x.addr = dram_addr;
               x.data = dram_rnw ? pat(dram_addr) : dram_wrdata;
               if (dram_rnw) dram_rddata = x.data;
               dram_next = 1'b1;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL dram_xact: unexpected rnw=%0b addr=%h data=%h", x.rnw, x.addr, x.data);
               end else begin
                  e = exp_q.pop_front();
                  if (x !== e) begin
                     errors++;
                     $display("FAIL dram_xact: got rnw=%0b addr=%h data=%h, want rnw=%0b addr=%h data=%h",
                              x.rnw, x.addr, x.data, e.rnw, e.addr, e.data);
                  end
               end
            end
         end
      end
   end

   // Device responder: read data is a running counter; channel select is checked on reads.
   initial begin
      dev_stb = 1'b0;
      dev_rddata = '0;
      forever begin
         @(negedge clk);
         dev_stb = 1'b0;
         if (dev_req && !reset && !stall) begin
            dev_stb = 1'b1;
            if (dev_rnw) begin
               dev_rddata = 16'hD000 + 16'(dev_cnt);
               dev_cnt++;
               checks++;
               if (dev_ch !== exp_dev_ch) begin
                  errors++;
                  $display("FAIL dev_ch: got %0d, want %0d", dev_ch, exp_dev_ch);
               end
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) if (int_done[i] === 1'b1) int_cnt[i]++;
      if (gap_meas) begin
         if (dram_req) begin
            if (gap > max_gap) max_gap = gap;
            gap = 0;
         end else gap++;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
      $fatal(1);
   end

   task automatic wr_reg(input int ch, input int idx, input logic [7:0] d);
      @(negedge clk);
      reg_we = 1'b1; reg_ch = CW'(ch); reg_idx = 4'(idx); reg_wdata = d;
      @(negedge clk);
      reg_we = 1'b0;
   endtask

   task automatic setup(input int ch, input logic [AW-1:0] s, input logic [AW-1:0] d,
                        input logic [7:0] lm1, input logic [7:0] nm1,
                        input logic [7:0] ss, input logic [7:0] ds);
      wr_reg(ch, 0, s[7:0]);  wr_reg(ch, 1, s[15:8]); wr_reg(ch, 2, {3'b000, s[20:16]});
      wr_reg(ch, 3, d[7:0]);  wr_reg(ch, 4, d[15:8]); wr_reg(ch, 5, {3'b000, d[20:16]});
      wr_reg(ch, 6, lm1); wr_reg(ch, 7, nm1); wr_reg(ch, 8, ss); wr_reg(ch, 9, ds);
   endtask

   task automatic wait_clear(input logic [NCH-1:0] mask, input int limit, output bit ok);
      int n;
      n = 0;
      while ((ch_act & mask) != '0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      ok = ((ch_act & mask) == '0);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (ch_act !== '0)       begin errors++; $display("FAIL rst_act: got %b want 0", ch_act); end
      checks++; if (dram_req !== 1'b0)   begin errors++; $display("FAIL rst_dram_req: got %b want 0", dram_req); end
      checks++; if (dev_req !== 1'b0)    begin errors++; $display("FAIL rst_dev_req: got %b want 0", dev_req); end
      checks++; if (int_done !== '0)     begin errors++; $display("FAIL rst_int: got %b want 0", int_done); end
      checks++; if (dram_addr !== '0)    begin errors++; $display("FAIL rst_addr: got %h want 0", dram_addr); end
      checks++; if (dram_wrdata !== '0 || dev_wrdata !== '0) begin
         errors++; $display("FAIL rst_wrdata: got %h/%h want 0", dram_wrdata, dev_wrdata);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_ram2ram;
      bit ok;
      for (int k = 0; k < 4; k++) begin
         push(1'b1, AW'(32'h100 + k), pat(AW'(32'h100 + k)));
         push(1'b0, AW'(32'h200 + k), pat(AW'(32'h100 + k)));
      end
      setup(0, 21'h100, 21'h200, 8'd3, 8'd0, 8'd0, 8'd0);
      wr_reg(0, 10, 8'h12);
      @(negedge clk);
      checks++; if (dram_req !== 1'b0) begin errors++; $display("FAIL launch_lat_early: got req=%b want 0", dram_req); end
      @(negedge clk);
      checks++; if (dram_req !== 1'b1) begin errors++; $display("FAIL launch_lat: got req=%b want 1", dram_req); end
      wait_clear(4'b0001, 200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL r2r_timeout: ch_act=%b want 0", ch_act); end
      checks++; if (int_done[0] !== 1'b1) begin errors++; $display("FAIL r2r_int_edge: got %b want 1", int_done[0]); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL r2r_left: got %0d want 0", exp_q.size()); end
      repeat (3) @(negedge clk);
      checks++; if (int_cnt[0] != 1) begin errors++; $display("FAIL r2r_int_cnt: got %0d want 1", int_cnt[0]); end
   endtask

   task automatic test_dev2ram_stride;
      bit ok;
      logic [AW-1:0] a [6] = '{21'h40, 21'h41, 21'h50, 21'h51, 21'h60, 21'h61};
      dev_cnt = 0;
      exp_dev_ch = 2'd1;
      for (int k = 0; k < 6; k++) push(1'b0, a[k], 16'hD000 + 16'(k));
      setup(1, 21'h0, 21'h40, 8'd1, 8'd2, 8'd0, 8'h10);
      wr_reg(1, 10, 8'h18);
      wait_clear(4'b0010, 300, ok);
      checks++; if (!ok) begin errors++; $display("FAIL d2r_timeout: ch_act=%b want 0", ch_act); end
      checks++; if (int_done[1] !== 1'b1) begin errors++; $display("FAIL d2r_int_edge: got %b want 1", int_done[1]); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL d2r_left: got %0d want 0", exp_q.size()); end
      checks++; if (dev_cnt != 6) begin errors++; $display("FAIL d2r_dev_reads: got %0d want 6", dev_cnt); end
   endtask

   task automatic test_round_robin;
      bit ok;
      int n;
      for (int b = 0; b < 2; b++) begin
         for (int k = 0; k < 2; k++) begin
            push(1'b1, AW'(32'h300 + 2*b + k), pat(AW'(32'h300 + 2*b + k)));
            push(1'b0, AW'(32'h380 + 2*b + k), pat(AW'(32'h300 + 2*b + k)));
         end
         for (int k = 0; k < 2; k++) begin
            push(1'b1, AW'(32'h400 + 2*b + k), pat(AW'(32'h400 + 2*b + k)));
            push(1'b0, AW'(32'h480 + 2*b + k), pat(AW'(32'h400 + 2*b + k)));
         end
      end
      setup(2, 21'h300, 21'h380, 8'd1, 8'd1, 8'd0, 8'd0);
      setup(0, 21'h400, 21'h480, 8'd1, 8'd1, 8'd0, 8'd0);
      wr_reg(2, 10, 8'h02);
      wr_reg(0, 10, 8'h02);
      wr_reg(0, 6, 8'd0);
      n = 0;
      while (!dram_req && n < 50) begin @(negedge clk); n++; end
      gap = 0; max_gap = 0; gap_meas = 1;
      wait_clear(4'b0101, 400, ok);
      gap_meas = 0;
      checks++; if (!ok) begin errors++; $display("FAIL rr_timeout: ch_act=%b want 0", ch_act); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rr_left: got %0d want 0", exp_q.size()); end
      checks++; if (max_gap != 1) begin errors++; $display("FAIL rr_arb_gap: got %0d want 1", max_gap); end
      checks++; if (int_cnt[0] != 1 || int_cnt[2] != 0) begin
         errors++; $display("FAIL rr_int: got %0d/%0d want 1/0", int_cnt[0], int_cnt[2]);
      end
   endtask

   task automatic test_abort;
      bit ok;
      int n;
      stall = 1;
      push(1'b1, 21'h500, pat(21'h500));
      push(1'b0, 21'h600, pat(21'h500));
      setup(3, 21'h500, 21'h600, 8'd3, 8'd0, 8'd0, 8'd0);
      wr_reg(3, 10, 8'h12);
      n = 0;
      while (!dram_req && n < 50) begin @(negedge clk); n++; end
      checks++; if (dram_req !== 1'b1) begin errors++; $display("FAIL abort_start: got req=%b want 1", dram_req); end
      setup(1, 21'h800, 21'h880, 8'd1, 8'd0, 8'd0, 8'd0);
      wr_reg(1, 10, 8'h12);
      checks++; if (ch_act[1] !== 1'b1) begin errors++; $display("FAIL abort_waiter_act: got %b want 1", ch_act[1]); end
      wr_reg(1, 10, 8'h03);
      checks++; if (ch_act[1] !== 1'b0) begin errors++; $display("FAIL abort_nonowner: got %b want 0", ch_act[1]); end
      wr_reg(3, 10, 8'h03);
      checks++; if (ch_act[3] !== 1'b1) begin errors++; $display("FAIL abort_owner_hold: got %b want 1", ch_act[3]); end
      stall = 0;
      wait_clear(4'b1000, 100, ok);
      checks++; if (!ok) begin errors++; $display("FAIL abort_timeout: ch_act=%b want 0", ch_act); end
      repeat (10) @(negedge clk);
      checks++; if (dram_req !== 1'b0 || dev_req !== 1'b0) begin
         errors++; $display("FAIL abort_quiet: got req=%b/%b want 0/0", dram_req, dev_req);
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL abort_left: got %0d want 0", exp_q.size()); end
      checks++; if (int_cnt[3] != 0 || int_cnt[1] != 1) begin
         errors++; $display("FAIL abort_int: got %0d/%0d want 0/1", int_cnt[3], int_cnt[1]);
      end
   endtask

   task automatic test_wrap;
      bit ok;
      push(1'b1, 21'h1FFFFF, pat(21'h1FFFFF));
      push(1'b0, 21'h700,    pat(21'h1FFFFF));
      push(1'b1, 21'h000000, pat(21'h000000));
      push(1'b0, 21'h701,    pat(21'h000000));
      setup(0, 21'h1FFFFF, 21'h700, 8'd1, 8'd0, 8'd0, 8'd0);
      wr_reg(0, 10, 8'h02);
      wait_clear(4'b0001, 100, ok);
      checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout: ch_act=%b want 0", ch_act); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_left: got %0d want 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid;
      int n;
      stall_wr = 1;
      push(1'b1, 21'h900, pat(21'h900));
      setup(2, 21'h900, 21'hA00, 8'd3, 8'd0, 8'd0, 8'd0);
      wr_reg(2, 10, 8'h12);
      n = 0;
      while (!(dram_req && !dram_rnw) && n < 50) begin @(negedge clk); n++; end
      checks++; if (!(dram_req === 1'b1 && dram_rnw === 1'b0)) begin
         errors++; $display("FAIL rstmid_wr: got req=%b rnw=%b want 1/0", dram_req, dram_rnw);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (dram_req !== 1'b0 || dev_req !== 1'b0 || ch_act !== '0) begin
         errors++; $display("FAIL rstmid_drop: got req=%b/%b act=%b want 0/0/0", dram_req, dev_req, ch_act);
      end
      reset = 1'b0;
      stall_wr = 0;
      repeat (10) @(negedge clk);
      checks++; if (dram_req !== 1'b0 || ch_act !== '0) begin
         errors++; $display("FAIL rstmid_resume: got req=%b act=%b want 0/0", dram_req, ch_act);
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rstmid_left: got %0d want 0", exp_q.size()); end
   endtask

   initial begin
      test_reset;
      test_ram2ram;
      test_dev2ram_stride;
      test_round_robin;
      test_abort;
      test_wrap;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
